// File: rtl/dmem_busywait_controller.sv
// Fixed-latency data memory for the MEM stage: raises the pipeline stall,
// performs RV32I byte/half/word loads and stores, and flags misaligned or illegal accesses.
//
// state  | meaning
// S_IDLE | waiting for READ/WRITE; stall asserted combinationally on request
// S_WAIT | counting down LATENCY cycles; access happens when the counter hits 0
// S_DONE | one stall-free cycle so every pipeline register advances once
module dmem_busywait_controller #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] read_data_o,
  output logic        busywait_o,
  output logic        access_fault_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] read_data_q, read_data_d;
  logic        fault_q, fault_d;
  logic [31:0] mem_q [2**ADDR_BITS];

  logic [ADDR_BITS-1:0] widx;
  logic [1:0]  off;
  logic [31:0] rd_word, wr_word, load_data;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;
  logic        fault, busy, mem_we;
  logic        unused_addr;

  assign widx        = address_i[ADDR_BITS+1:2];
  assign off         = address_i[1:0];
  assign unused_addr = ^address_i[31:ADDR_BITS+2];
  assign rd_word     = mem_q[widx];
  assign lbyte       = rd_word[{off, 3'b000} +: 8];
  assign lhalf       = off[1] ? rd_word[31:16] : rd_word[15:0];

  // WRITE wins when both request lines are high, so decode against the store table.
  always_comb begin
    fault = 1'b0;
    if (write_i) begin
      case (func3_i)
        3'b000:  fault = 1'b0;
        3'b001:  fault = off[0];
        3'b010:  fault = |off;
        default: fault = 1'b1;
      endcase
    end else begin
      case (func3_i)
        3'b000, 3'b100: fault = 1'b0;
        3'b001, 3'b101: fault = off[0];
        3'b010:         fault = |off;
        default:        fault = 1'b1;
      endcase
    end
  end

  always_comb begin
    load_data = rd_word;
    case (func3_i)
      3'b000:  load_data = {{24{lbyte[7]}}, lbyte};
      3'b001:  load_data = {{16{lhalf[15]}}, lhalf};
      3'b100:  load_data = {24'h0, lbyte};
      3'b101:  load_data = {16'h0, lhalf};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    wr_word = rd_word;
    case (func3_i)
      3'b000: wr_word[{off, 3'b000} +: 8] = write_data_i[7:0];
      3'b001: begin
        if (off[1]) wr_word[31:16] = write_data_i[15:0];
        else        wr_word[15:0]  = write_data_i[15:0];
      end
      default: wr_word = write_data_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    fault_d     = fault_q;
    busy        = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read_i || write_i) begin
          busy    = 1'b1;
          state_d = S_WAIT;
          cnt_d   = LAT_M1;
          fault_d = 1'b0;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (fault) begin
            fault_d     = 1'b1;
            read_data_d = 32'h0;
          end else if (write_i) begin
            mem_we = 1'b1;
          end else begin
            read_data_d = load_data;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (reset_i) begin
      busy   = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      read_data_q <= 32'h0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[widx] <= wr_word;
  end

  assign busywait_o     = busy;
  assign read_data_o    = read_data_q;
  assign access_fault_o = fault_q;

endmodule
